// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the seven-segment scan controller
// Purpose: scan FSM state encoding, digit value width, reset blank pattern, helper.
// Ports: none (package).
package seven_seg_pkg;

  localparam int DIGIT_W = 3;

  // A digit is dark until the first committed load.
  localparam logic RESET_BLANK_BIT = 1'b1;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - load request/acknowledge bundle for new display data
// Purpose: groups the req/ack handshake that delivers digit values and blank flags.
// Signals: load_req (requester holds until ack), load_data (DIGIT_W per digit),
//          load_blank (one per digit), load_ack (one-cycle capture pulse).
// Modports: master = requester side, slave = scan controller side.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import seven_seg_pkg::*;

  logic                          load_req;
  logic [DIGIT_W*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]         load_blank;
  logic                          load_ack;

  modport master (
    output load_req,
    output load_data,
    output load_blank,
    input  load_ack
  );

  modport slave (
    input  load_req,
    input  load_data,
    input  load_blank,
    output load_ack
  );

endinterface

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
// rtl/seven_seg_scan_ctrl_scan_timer.sv - loadable down-counter with hold and expire flag
// Purpose: times the blank and drive intervals of each digit slot.
// Ports: clk, rst_n (async active-low), load_i/load_val_i (reload, wins over hold),
//        hold_i (freeze count), expired_o (count has reached zero).
module scan_timer #(
  parameter int          W         = 4,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         hold_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (!hold_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed scan of NUM_DIGITS digits over one shared decoder
// Purpose: per-digit blank guard then drive interval, shadowed data committed at frame boundaries.
// Ports: clk, rst_n (async active-low), en_i (scan enable),
//        load_if (slave side of the load handshake),
//        dec_in_o (value to the shared decoder), digit_en_o (one-hot digit enable),
//        frame_done_o (pulse after the last digit's drive interval).
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  seven_seg_scan_ctrl_if.slave     load_if,
  output logic [DIGIT_W-1:0]       dec_in_o,
  output logic [NUM_DIGITS-1:0]    digit_en_o,
  output logic                     frame_done_o
);

  localparam int TMR_W  = $clog2(max_int(REFRESH_DIV, BLANK_CYCLES) + 1);
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int DATA_W = DIGIT_W * NUM_DIGITS;

  localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRIVE_LOAD = TMR_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e              state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]        active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]    active_blank_q, active_blank_d;
  logic [DATA_W-1:0]        shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]    shadow_blank_q, shadow_blank_d;
  logic                     pend_valid_q, pend_valid_d;
  logic                     load_ack_q, load_ack_d;
  logic                     frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]    digit_en_q, digit_en_d;
  logic [DIGIT_W-1:0]       dec_in_q, dec_in_d;

  logic                     tmr_expired;
  logic                     tmr_load;
  logic [TMR_W-1:0]         tmr_load_val;

  scan_timer #(
    .W         (TMR_W),
    .RESET_VAL (BLANK_LOAD)
  ) u_scan_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .hold_i     (!en_i),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    active_data_d  = active_data_q;
    active_blank_d = active_blank_q;
    shadow_data_d  = shadow_data_q;
    shadow_blank_d = shadow_blank_q;
    pend_valid_d   = pend_valid_q;
    load_ack_d     = 1'b0;
    frame_done_d   = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_val   = BLANK_LOAD;
    digit_en_d     = '0;
    dec_in_d       = '0;

    // Slot sequencing only advances while enabled; with en low the timer holds too.
    if (en_i && tmr_expired) begin
      tmr_load = 1'b1;
      if (state_q == BLANK) begin
        state_d      = DRIVE;
        tmr_load_val = DRIVE_LOAD;
      end else begin
        state_d      = BLANK;
        tmr_load_val = BLANK_LOAD;
        if (idx_q == LAST_IDX) begin
          idx_d        = '0;
          frame_done_d = 1'b1;
          if (pend_valid_q) begin
            active_data_d  = shadow_data_q;
            active_blank_d = shadow_blank_q;
            pend_valid_d   = 1'b0;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end

    // Capture looks at the pre-edge pend flag, so a commit on this edge
    // pushes any waiting request to the following cycle.
    if (load_if.load_req && !pend_valid_q) begin
      shadow_data_d  = load_if.load_data;
      shadow_blank_d = load_if.load_blank;
      pend_valid_d   = 1'b1;
      load_ack_d     = 1'b1;
    end

    // Outputs follow the post-edge state so they change on the entering edge.
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        dec_in_d = active_data_d[k*DIGIT_W +: DIGIT_W];
        if (en_i && (state_d == DRIVE) && !active_blank_d[k]) begin
          digit_en_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= BLANK;
      idx_q          <= '0;
      active_data_q  <= '0;
      active_blank_q <= {NUM_DIGITS{RESET_BLANK_BIT}};
      shadow_data_q  <= '0;
      shadow_blank_q <= '0;
      pend_valid_q   <= 1'b0;
      load_ack_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      digit_en_q     <= '0;
      dec_in_q       <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      active_data_q  <= active_data_d;
      active_blank_q <= active_blank_d;
      shadow_data_q  <= shadow_data_d;
      shadow_blank_q <= shadow_blank_d;
      pend_valid_q   <= pend_valid_d;
      load_ack_q     <= load_ack_d;
      frame_done_q   <= frame_done_d;
      digit_en_q     <= digit_en_d;
      dec_in_q       <= dec_in_d;
    end
  end

  assign load_if.load_ack = load_ack_q;
  assign dec_in_o         = dec_in_q;
  assign digit_en_o       = digit_en_q;
  assign frame_done_o     = frame_done_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexes one shared seven_segment_cntrl decoder across NUM_DIGITS common-cathode digits. Each digit slot has a blanking guard interval and a drive interval. During the drive interval the block presents that digit's 3-bit value on the decoder input and enables exactly one digit. New display data arrives through a req/ack handshake into a shadow register and is committed only at a frame boundary, so a frame never shows a mix of old and new data.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
REFRESH_DIV, 50000, clk cycles each digit is driven (>=1)
BLANK_CYCLES, 8, clk cycles all digits are off before each digit is driven (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 freezes scan and forces digits off
load_req  in  1  requester holds high with load_data/load_blank stable until load_ack
load_data  in  3*NUM_DIGITS  digit values; digit k is bits [3k+2:3k]
load_blank  in  NUM_DIGITS  per-digit blank; 1 keeps that digit dark
load_ack  out  1  one-cycle pulse: request captured
dec_in  out  3  value to the shared decoder's `in`
digit_en  out  NUM_DIGITS  one-hot digit enable, active high
frame_done  out  1  one-cycle pulse after the last digit's drive interval

Behaviour:
- Async reset values: dec_in=0, digit_en=0, load_ack=0, frame_done=0, idx=0, state=BLANK, timer=BLANK_CYCLES-1, active_data=0, active_blank=all-ones (dark until first commit), pend_valid=0.
- FSM states:
  - BLANK: digit_en=0 and dec_in=active value of idx. When the timer expires (BLANK_CYCLES cycles), go to DRIVE and load timer=REFRESH_DIV-1.
  - DRIVE: digit_en[idx]=~active_blank[idx] and dec_in=active_data[idx]. On expiry (REFRESH_DIV cycles), go to BLANK and load timer=BLANK_CYCLES-1.
  - On the DRIVE->BLANK transition, idx advances. It wraps from NUM_DIGITS-1 to 0.
- Frame boundary (DRIVE->BLANK with idx==NUM_DIGITS-1):
  - frame_done=1 for the next cycle.
  - If pend_valid, active_data/active_blank take the shadow contents and pend_valid clears in the same edge.
  - Frame length is NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- All outputs are registered. digit_en/dec_in change on the edge that enters the new state.
- Handshake:
  - Capture: when load_req=1 and pend_valid=0, the shadow captures load_data/load_blank, pend_valid sets, and load_ack=1 the following cycle.
  - Back-pressure: if pend_valid=1, load_ack stays low until the slot frees at the next frame boundary; capture happens on the first cycle after that.
  - Simultaneous commit and capture in one cycle is not allowed; the commit has priority. The request is captured on the next cycle.
  - A request withdrawn before ack is ignored.
- en=0:
  - digit_en=0 next cycle; the timer, idx and state hold.
  - The handshake still operates and commits do not occur.
  - When en returns to 1, the scan resumes from the held state and count.
- Reset mid-frame or mid-handshake: everything returns to reset values; a pending shadow is discarded.
- digit_en never has more than one bit set, and is all-zero throughout BLANK.
- Timer width is $clog2(max(REFRESH_DIV,BLANK_CYCLES)+1).

Decomposition:
- Package seven_seg_pkg holds the state enum {BLANK, DRIVE}, DIGIT_W=3 and the reset blank pattern.
- One sub-module, scan_timer: a loadable down-counter with hold and an expire flag, parameterised by width.
- The decoder is instantiated outside this block; dec_in connects to its `in`.

Test Plan:
(Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2.)
1. Reset release with no load -> digit_en stays 0 for 100 cycles. The first frame_done occurs at cycle 24 and repeats every 24 cycles.
2. Load data=12'o7531 (d0=1, d1=3, d2=5, d3=7) with blank=0 -> load_ack occurs 1 cycle after req. After the next frame_done, the sequence is digit_en 0001/dec_in=1, 0010/3, 0100/5, 1000/7, each for 4 cycles separated by 2 all-zero cycles.
3. Two back-to-back loads (second data=12'o0000) -> second ack is delayed until the cycle after a frame boundary. The second data appears only in the frame after that.
4. load_blank=4'b0100 -> digit_en never has bit 2 set, while slot timing is unchanged (still 24-cycle frame).
5. en dropped for 10 cycles mid-DRIVE of digit 1 -> digit_en=0 during the gap. After resume, digit 1 is driven for its remaining cycles, and frame_done is delayed by exactly 10 cycles.
6. rst_n asserted mid-DRIVE with pend_valid=1 -> outputs are immediately 0. After release, the display stays dark (active_blank all-ones) and no stale commit occurs.
